// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Iterative AES encryption controller that steps one shared
//               round datapath over Nr rounds for AES-128/192/256.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    input  logic [1:0]          key_len,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic [127:0]        dp_state,
    output logic                dp_final,
    input  logic [127:0]        dp_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy,
    output logic                cfg_err
);

    localparam logic [RK_IDX_W-1:0] C_NR_128 = RK_IDX_W'(10);
    localparam logic [RK_IDX_W-1:0] C_NR_192 = RK_IDX_W'(12);
    localparam logic [RK_IDX_W-1:0] C_NR_256 = RK_IDX_W'(14);
    localparam logic [RK_IDX_W-1:0] C_ONE    = RK_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t                r_fsm;
    fsm_t                w_fsm_nxt;
    logic [127:0]        r_state;
    logic [127:0]        w_state_nxt;
    logic [RK_IDX_W-1:0] r_round;
    logic [RK_IDX_W-1:0] w_round_nxt;
    logic [RK_IDX_W-1:0] r_nr;
    logic [RK_IDX_W-1:0] w_nr_nxt;
    logic                r_cfg_err;
    logic                w_cfg_err_nxt;
    logic                w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm     <= S_IDLE;
            r_state   <= '0;
            r_round   <= '0;
            r_nr      <= C_NR_128;
            r_cfg_err <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_state   <= w_state_nxt;
            r_round   <= w_round_nxt;
            r_nr      <= w_nr_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign w_last = (r_round == r_nr);

    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_state_nxt   = r_state;
        w_round_nxt   = r_round;
        w_nr_nxt      = r_nr;
        w_cfg_err_nxt = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        rk_idx        = '0;
        dp_final      = 1'b0;

        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Initial AddRoundKey is folded into the accept cycle.
                    w_state_nxt   = in_block ^ rk;
                    w_round_nxt   = C_ONE;
                    w_fsm_nxt     = S_RUN;
                    w_cfg_err_nxt = (key_len == 2'b11);
                    case (key_len)
                        2'b01:   w_nr_nxt = C_NR_192;
                        2'b10:   w_nr_nxt = C_NR_256;
                        default: w_nr_nxt = C_NR_128;
                    endcase
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                rk_idx      = r_round;
                dp_final    = w_last;
                w_state_nxt = dp_result;
                // The round counter saturates at nr so it never leaves range.
                if (w_last) begin
                    w_fsm_nxt = S_DONE;
                end else begin
                    w_round_nxt = r_round + C_ONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_nxt   = S_IDLE;
                    w_round_nxt = '0;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign dp_state  = r_state;
    assign out_block = r_state;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
